// File: rtl/multi_tc_if.sv
// Register-bus and interrupt bundle for multi_tc: word-addressed CPU access
// with byte-lane writes, combinational read data and per-channel IRQ lines.
interface multi_tc_if #(
    parameter int ADDR_W = 6,
    parameter int NUM_CH = 2
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [3:0]        byteen;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic [NUM_CH-1:0] irq;
    logic              irq_any;

    modport slave  (input addr, we, byteen, din, output dout, irq, irq_any);
    modport master (output addr, we, byteen, din, input dout, irq, irq_any);
endinterface

// File: rtl/multi_tc.sv
// NUM_CH independent prescaled down-counters with one-shot/auto-reload modes,
// a sticky W1C status register and maskable per-channel interrupts.
module multi_tc #(
    parameter int NUM_CH  = 2,
    parameter int COUNT_W = 32,
    parameter int PSC_W   = 8,
    parameter int ADDR_W  = 6
) (
    input  logic       clk,
    input  logic       reset,
    multi_tc_if.slave  bus
);
    localparam int STATUS_ADDR = NUM_CH * 4;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    logic [31:0]       wmask;
    logic [31:0]       ctrl_rd   [NUM_CH];
    logic [31:0]       preset_rd [NUM_CH];
    logic [31:0]       count_rd  [NUM_CH];
    logic [NUM_CH-1:0] status_q;
    logic [NUM_CH-1:0] status_set;
    logic [NUM_CH-1:0] w1c;
    logic [NUM_CH-1:0] im_vec;
    logic [NUM_CH-1:0] irq_w;
    logic [31:0]       rdata;

    assign wmask = {{8{bus.byteen[3]}}, {8{bus.byteen[2]}},
                    {8{bus.byteen[1]}}, {8{bus.byteen[0]}}};

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t             state_q, state_d;
            logic               en_q, mode_q, im_q;
            logic [PSC_W-1:0]   psc_q, pcnt_q, pcnt_d;
            logic [COUNT_W-1:0] preset_q, count_q, count_d;
            logic               ctrl_we, preset_we, hw_en_clr, set_c;

            assign ctrl_we   = bus.we && (int'(bus.addr) == gi * 4);
            assign preset_we = bus.we && (int'(bus.addr) == gi * 4 + 1);

            always_comb begin
                state_d   = state_q;
                count_d   = count_q;
                pcnt_d    = pcnt_q;
                set_c     = 1'b0;
                hw_en_clr = 1'b0;
                case (state_q)
                    S_IDLE: if (en_q) state_d = S_LOAD;
                    S_LOAD: begin
                        count_d = preset_q;
                        pcnt_d  = '0;
                        state_d = S_CNT;
                    end
                    S_CNT: begin
                        if (!en_q) begin
                            state_d = S_IDLE;
                        end else if (count_q == '0) begin
                            state_d = S_INT;
                            set_c   = 1'b1;
                        end else if (pcnt_q == psc_q) begin
                            count_d = count_q - COUNT_W'(1);
                            pcnt_d  = '0;
                        end else begin
                            pcnt_d  = pcnt_q + PSC_W'(1);
                        end
                    end
                    S_INT: begin
                        if (mode_q) begin
                            state_d = S_LOAD;
                        end else begin
                            hw_en_clr = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q  <= S_IDLE;
                    count_q  <= '0;
                    pcnt_q   <= '0;
                    en_q     <= 1'b0;
                    mode_q   <= 1'b0;
                    im_q     <= 1'b0;
                    psc_q    <= '0;
                    preset_q <= '0;
                end else begin
                    state_q <= state_d;
                    count_q <= count_d;
                    pcnt_q  <= pcnt_d;
                    if (ctrl_we && bus.byteen[0]) begin
                        en_q   <= bus.din[0];
                        mode_q <= bus.din[1];
                        im_q   <= bus.din[3];
                    end
                    if (ctrl_we && bus.byteen[1]) psc_q <= bus.din[8 +: PSC_W];
                    // The one-shot hardware clear must override a CPU write on the same edge.
                    if (hw_en_clr) en_q <= 1'b0;
                    if (preset_we) begin
                        preset_q <= (preset_q & ~wmask[COUNT_W-1:0]) |
                                    (bus.din[COUNT_W-1:0] & wmask[COUNT_W-1:0]);
                    end
                end
            end

            assign status_set[gi] = set_c;
            assign im_vec[gi]     = im_q;
            assign ctrl_rd[gi]    = 32'({psc_q, 4'b0000, im_q, 1'b0, mode_q, en_q});
            assign preset_rd[gi]  = 32'(preset_q);
            assign count_rd[gi]   = 32'(count_q);
        end
    endgenerate

    assign w1c = (bus.we && bus.byteen[0] && (int'(bus.addr) == STATUS_ADDR))
                 ? bus.din[NUM_CH-1:0] : '0;

    // A hardware set on the same edge as a software clear must survive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) status_q <= '0;
        else        status_q <= (status_q & ~w1c) | status_set;
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(bus.addr) == c * 4)     rdata = ctrl_rd[c];
            if (int'(bus.addr) == c * 4 + 1) rdata = preset_rd[c];
            if (int'(bus.addr) == c * 4 + 2) rdata = count_rd[c];
        end
        if (int'(bus.addr) == STATUS_ADDR) rdata = 32'(status_q);
    end

    assign irq_w       = status_q & im_vec;
    assign bus.irq     = irq_w;
    assign bus.irq_any = |irq_w;
    assign bus.dout    = rdata;
endmodule

// File: doc/multi_tc.md
Name: multi_tc

Overview:
- Parametrised multi-channel timer/counter; successor to the fixed pair of single-channel timers on the bridge.
- NUM_CH independent down-counters, each with:
  - one-shot or auto-reload mode
  - programmable prescaler
  - sticky, maskable interrupt status
- A global status register is write-1-to-clear. Per-channel IRQs feed the CPU HWInt vector; irq_any gives a single-line hookup.

Parameters:
NUM_CH, 2, number of timer channels (1..8)
COUNT_W, 32, counter/preset width in bits (8..32)
PSC_W, 8, prescaler divisor field width (1..8)
ADDR_W, 6, word-address width; must cover (NUM_CH*4+1) words

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous active-low reset (0 = reset)
addr  in  ADDR_W  word offset within block (byte address bits [ADDR_W+1:2])
we  in  1  write strobe, sampled on rising clk
byteen  in  4  byte-lane enables for writes
din  in  32  write data
dout  out  32  combinational read data for addr
irq  out  NUM_CH  per-channel interrupt = status[c] & CTRL[c].IM
irq_any  out  1  OR of irq

Behaviour:
Register map (word offsets):
- c*4+0: CTRL
  - [0] EN
  - [1] MODE (0 one-shot, 1 auto-reload)
  - [3] IM
  - [8+PSC_W-1:8] PSC
  - other bits read 0
- c*4+1: PRESET, COUNT_W bits
- c*4+2: COUNT, read-only
- c*4+3: reserved, reads 0
- NUM_CH*4: STATUS, bit c = channel c pending; write 1 clears, write 0 has no effect
- Out-of-range reads return 0; out-of-range writes are ignored.

Register access:
- Writes apply per byte lane selected by byteen.
- Bits beyond COUNT_W/PSC_W are dropped; the upper bits read 0.
- Writes to COUNT are ignored.

Reset (reset=0, asynchronous):
- All CTRL, PRESET, COUNT, STATUS and prescaler counters are 0.
- Every FSM is in IDLE.
- irq = 0, irq_any = 0, dout = 0 for valid registers.

Per-channel FSM (IDLE, LOAD, CNT, INT):
- IDLE: EN=1 -> LOAD.
- LOAD: COUNT <= PRESET; prescaler counter <= 0; -> CNT.
- CNT:
  - EN=0 -> IDLE; COUNT holds.
  - COUNT==0 -> INT, and STATUS[c] is set on that same edge.
  - Otherwise a tick fires when the prescaler counter == PSC. On a tick, COUNT decrements and the prescaler counter goes to 0; otherwise the prescaler counter increments.
- INT:
  - MODE=0: EN cleared by hardware -> IDLE.
  - MODE=1: -> LOAD.

Timing:
- From the edge writing EN=1, STATUS sets on edge number PRESET*(PSC+1)+3.
- Auto-reload period is PRESET*(PSC+1)+3 cycles.
- PRESET=0 gives an interrupt 3 edges after enable.

Boundary and simultaneous cases:
- Hardware STATUS set and software W1C of the same bit on the same edge: set wins.
- CPU write of CTRL in the same cycle the FSM is in INT with MODE=0: the hardware EN clear wins for bit 0; other fields take the CPU value.
- PRESET written mid-count: takes effect at the next LOAD only.
- EN cleared then re-set: restarts from LOAD (full reload), not from the held COUNT.
- IM=0 masks irq but not STATUS; setting IM while the bit is pending asserts irq the next cycle.
- Reset asserted mid-count: immediate return to reset values; no IRQ glitch after release.
- Channels are fully independent; simultaneous expiry sets multiple STATUS bits on one edge.

Test Plan:
1. Reset: assert reset=0 mid-count with irq=1 -> irq=0, COUNT=0, STATUS=0 immediately; all regs read 0 after release.
2. One-shot: PRESET=3, PSC=0, CTRL=0x9 (EN, IM, one-shot) on ch0.
   - irq[0] rises after the 6th edge.
   - COUNT sequence reads 3,2,1,0.
   - CTRL.EN reads 0 afterwards.
   - Write STATUS=0x1 -> irq[0]=0.
3. Auto-reload with prescaler: ch1 PRESET=2, PSC=3, CTRL=0x30B (PSC=3, MODE=1, IM, EN).
   - STATUS[1] first sets 11 edges after enable.
   - W1C each time; it re-sets every 11 cycles.
   - COUNT changes only every 4th cycle.
4. Simultaneous set/clear: W1C STATUS bit 0 on the exact expiry edge -> bit reads 1 afterwards.
5. Masking and multi-channel:
   - ch0 and ch1 both PRESET=5, IM=0, enabled on the same edge -> STATUS=0x3 on the same edge, irq=0.
   - Set IM on ch1 -> irq=0x2, irq_any=1.
6. Byte lanes and range:
   - Write PRESET=0xAABBCCDD with byteen=0101 -> reads 0x00BB00DD.
   - Write to COUNT -> no change.
   - Read offset NUM_CH*4+1 -> 0.
